branch_predictor: RTL and testbench

- Branch prediction unit: the consumer end of the issue stage's predictor-update bus (PHT/BTB write ports).
- The fetch stage presents a fetch PC; one cycle later the block returns a 36-bit prediction word {predict_taken, predict_state[1:0], btb_hit, predict_target[31:0]}.
- The issue stage carries that word with the instruction and writes resolved outcomes back through the PHT/BTB write ports.
- Contents: a direct-mapped PHT of 2-bit saturating-counter states and a direct-mapped, tagged BTB.

---
 rtl/branch_predictor_if.sv | 29 ++
 rtl/branch_predictor.sv | 114 +++++++++++
 tb/tb_branch_predictor.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/issue-side bus of the branch predictor: lookup request, prediction
// response and the PHT/BTB write ports driven by the issue stage.
interface branch_predictor_if;
  logic        lookup_en_i;
  logic [31:0] lookup_pc_i;
  logic        flush_i;
  logic        bp_valid_o;
  logic [35:0] bp_info_o;
  logic        pht_we_i;
  logic [31:0] pht_wpc_i;
  logic [1:0]  pht_wstate_i;
  logic        btb_we_i;
  logic [31:0] btb_wpc_i;
  logic [31:0] btb_wtarget_i;

  modport master (
    output lookup_en_i, lookup_pc_i, flush_i,
    output pht_we_i, pht_wpc_i, pht_wstate_i,
    output btb_we_i, btb_wpc_i, btb_wtarget_i,
    input  bp_valid_o, bp_info_o
  );

  modport slave (
    input  lookup_en_i, lookup_pc_i, flush_i,
    input  pht_we_i, pht_wpc_i, pht_wstate_i,
    input  btb_we_i, btb_wpc_i, btb_wtarget_i,
    output bp_valid_o, bp_info_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit PHT plus tagged direct-mapped BTB, one-cycle lookup
// with same-cycle write bypass so a prediction always reflects the newest writes.
module branch_predictor #(
  parameter int PHT_IDX_W = 8,
  parameter int BTB_IDX_W = 6,
  parameter int BTB_TAG_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  branch_predictor_if.slave bp
);

  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;

  logic [1:0]           r_pht_state  [PHT_N];
  logic [BTB_N-1:0]     r_btb_valid;
  logic [BTB_TAG_W-1:0] r_btb_tag    [BTB_N];
  logic [31:0]          r_btb_target [BTB_N];

  logic        r_bp_valid;
  logic [35:0] r_bp_info;

  logic [PHT_IDX_W-1:0] w_pht_ridx;
  logic [PHT_IDX_W-1:0] w_pht_widx;
  logic [BTB_IDX_W-1:0] w_btb_ridx;
  logic [BTB_IDX_W-1:0] w_btb_widx;
  logic [BTB_TAG_W-1:0] w_lookup_tag;
  logic [BTB_TAG_W-1:0] w_write_tag;
  logic                 w_pht_bypass;
  logic                 w_btb_bypass;
  logic [1:0]           w_state;
  logic                 w_entry_valid;
  logic [BTB_TAG_W-1:0] w_entry_tag;
  logic [31:0]          w_entry_target;
  logic                 w_hit;
  logic                 w_taken;
  logic [31:0]          w_target;
  logic [35:0]          w_info;
  logic                 w_unused;

  assign w_pht_ridx   = bp.lookup_pc_i[2 +: PHT_IDX_W];
  assign w_pht_widx   = bp.pht_wpc_i[2 +: PHT_IDX_W];
  assign w_btb_ridx   = bp.lookup_pc_i[2 +: BTB_IDX_W];
  assign w_btb_widx   = bp.btb_wpc_i[2 +: BTB_IDX_W];
  assign w_lookup_tag = bp.lookup_pc_i[2 + BTB_IDX_W +: BTB_TAG_W];
  assign w_write_tag  = bp.btb_wpc_i[2 + BTB_IDX_W +: BTB_TAG_W];

  // Byte-offset and high PC bits outside index/tag are don't-care.
  assign w_unused = ^{bp.lookup_pc_i, bp.pht_wpc_i, bp.btb_wpc_i};

  // PHT storage: reset to weakly not-taken, writes store the issue stage's state verbatim.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_N; i++) begin
        r_pht_state[i] <= 2'b01;
      end
    end else if (bp.pht_we_i) begin
      r_pht_state[w_pht_widx] <= bp.pht_wstate_i;
    end
  end

  // BTB valid bits: cleared on reset, set by any BTB write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btb_valid <= '0;
    end else if (bp.btb_we_i) begin
      r_btb_valid[w_btb_widx] <= 1'b1;
    end
  end

  // BTB tag/target payload: only meaningful behind a valid bit, so no reset.
  always_ff @(posedge clk) begin
    if (!reset && bp.btb_we_i) begin
      r_btb_tag[w_btb_widx]    <= w_write_tag;
      r_btb_target[w_btb_widx] <= bp.btb_wtarget_i;
    end
  end

  // Lookup datapath with write-first bypass of both tables.
  always_comb begin
    w_pht_bypass   = bp.pht_we_i && (w_pht_widx == w_pht_ridx);
    w_btb_bypass   = bp.btb_we_i && (w_btb_widx == w_btb_ridx);
    w_state        = w_pht_bypass ? bp.pht_wstate_i : r_pht_state[w_pht_ridx];
    w_entry_valid  = w_btb_bypass ? 1'b1 : r_btb_valid[w_btb_ridx];
    w_entry_tag    = w_btb_bypass ? w_write_tag : r_btb_tag[w_btb_ridx];
    w_entry_target = w_btb_bypass ? bp.btb_wtarget_i : r_btb_target[w_btb_ridx];
    w_hit          = w_entry_valid && (w_entry_tag == w_lookup_tag);
    w_taken        = w_hit && w_state[1];
    w_target       = w_hit ? w_entry_target : (bp.lookup_pc_i + 32'd4);
    w_info         = {w_taken, w_state, w_hit, w_target};
  end

  // Prediction register: new lookup wins over flush; stall holds everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bp_valid <= 1'b0;
      r_bp_info  <= 36'h0;
    end else if (bp.lookup_en_i) begin
      r_bp_valid <= 1'b1;
      r_bp_info  <= w_info;
    end else if (bp.flush_i) begin
      r_bp_valid <= 1'b0;
      r_bp_info  <= r_bp_info;
    end else begin
      r_bp_valid <= r_bp_valid;
      r_bp_info  <= r_bp_info;
    end
  end

  assign bp.bp_valid_o = r_bp_valid;
  assign bp.bp_info_o  = r_bp_info;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized bench for branch_predictor against a table-level
// reference model that applies writes first and then answers the lookup.
module tb_branch_predictor;

  localparam int PHT_IDX_W = 8;
  localparam int BTB_IDX_W = 6;
  localparam int BTB_TAG_W = 10;
  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;

  logic clk;
  logic reset;
  branch_predictor_if bus ();

  branch_predictor #(
    .PHT_IDX_W(PHT_IDX_W),
    .BTB_IDX_W(BTB_IDX_W),
    .BTB_TAG_W(BTB_TAG_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bp   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned m_pht [PHT_N];
  bit          m_bv  [BTB_N];
  int unsigned m_bt  [BTB_N];
  logic [31:0] m_btg [BTB_N];
  logic        exp_valid;
  logic [35:0] exp_info;
  int          errors;
  int          checks;

  function automatic logic [35:0] model_predict(input logic [31:0] pc);
    int unsigned pidx, bidx, tag, st;
    bit          hit;
    logic [31:0] tgt;
    pidx = (pc / 4) % PHT_N;
    bidx = (pc / 4) % BTB_N;
    tag  = (pc / (4 * BTB_N)) % (1 << BTB_TAG_W);
    st   = m_pht[pidx];
    hit  = m_bv[bidx] && (m_bt[bidx] == tag);
    tgt  = hit ? m_btg[bidx] : pc + 32'd4;
    return {hit && (st >= 2), st[1:0], hit, tgt};
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check36(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit le, input logic [31:0] lpc, input bit fl,
                      input bit pwe, input logic [31:0] ppc, input logic [1:0] pst,
                      input bit bwe, input logic [31:0] bpc, input logic [31:0] btg,
                      input string tag);
    reset = rst;
    bus.lookup_en_i = le;  bus.lookup_pc_i = lpc;  bus.flush_i = fl;
    bus.pht_we_i = pwe;    bus.pht_wpc_i = ppc;    bus.pht_wstate_i = pst;
    bus.btb_we_i = bwe;    bus.btb_wpc_i = bpc;    bus.btb_wtarget_i = btg;
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) m_pht[i] = 1;
      for (int i = 0; i < BTB_N; i++) m_bv[i] = 1'b0;
      exp_valid = 1'b0;
      exp_info  = 36'h0;
    end else begin
      if (pwe) m_pht[(ppc / 4) % PHT_N] = pst;
      if (bwe) begin
        m_bv[(bpc / 4) % BTB_N]  = 1'b1;
        m_bt[(bpc / 4) % BTB_N]  = (bpc / (4 * BTB_N)) % (1 << BTB_TAG_W);
        m_btg[(bpc / 4) % BTB_N] = btg;
      end
      if (le) begin
        exp_valid = 1'b1;
        exp_info  = model_predict(lpc);
      end else if (fl) begin
        exp_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check1({tag, "_valid"}, bus.bp_valid_o, exp_valid);
    check36({tag, "_info"}, bus.bp_info_o, exp_info);
  endtask

  task automatic lookup(input logic [31:0] pc, input string tag);
    step(0, 1, pc, 0, 0, 0, 2'b00, 0, 0, 0, tag);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, tag);
  endtask

  initial begin
    logic [35:0] held;
    errors = 0;
    checks = 0;
    exp_valid = 1'b0;
    exp_info  = 36'h0;
    reset = 1'b1;
    bus.lookup_en_i = 1'b0; bus.lookup_pc_i = 32'h0; bus.flush_i = 1'b0;
    bus.pht_we_i = 1'b0; bus.pht_wpc_i = 32'h0; bus.pht_wstate_i = 2'b00;
    bus.btb_we_i = 1'b0; bus.btb_wpc_i = 32'h0; bus.btb_wtarget_i = 32'h0;

    step(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, "reset");
    check36("reset_const", bus.bp_info_o, 36'h0);

    lookup(32'h1C00_0000, "first_lookup");
    check36("first_const", bus.bp_info_o, {1'b0, 2'b01, 1'b0, 32'h1C00_0004});

    step(0, 0, 0, 0, 1, 32'h1C00_0010, 2'b11, 1, 32'h1C00_0010, 32'h1C00_0100, "wr_btb_pht");
    idle("wr_gap");
    lookup(32'h1C00_0010, "hit_st11");
    check36("hit_st11_const", bus.bp_info_o, {1'b1, 2'b11, 1'b1, 32'h1C00_0100});
    step(0, 0, 0, 0, 1, 32'h1C00_0010, 2'b10, 0, 0, 0, "wr_st10");
    lookup(32'h1C00_0010, "hit_st10");
    check1("hit_st10_taken", bus.bp_info_o[35], 1'b1);
    step(0, 0, 0, 0, 1, 32'h1C00_0010, 2'b01, 0, 0, 0, "wr_st01");
    lookup(32'h1C00_0010, "hit_st01");
    check36("hit_st01_const", bus.bp_info_o, {1'b0, 2'b01, 1'b1, 32'h1C00_0100});

    lookup(32'h1C00_0010 + (32'd1 << (2 + BTB_IDX_W)), "alias");
    check36("alias_const", bus.bp_info_o, {1'b0, 2'b01, 1'b0, 32'h1C00_0114});

    step(0, 1, 32'h1C00_0020, 0, 1, 32'h1C00_0020, 2'b11, 1, 32'h1C00_0020, 32'h1C00_0200, "bypass");
    check36("bypass_const", bus.bp_info_o, {1'b1, 2'b11, 1'b1, 32'h1C00_0200});

    lookup(32'h1C00_0020, "hold_lookup");
    held = bus.bp_info_o;
    for (int i = 0; i < 3; i++) idle("hold");
    check36("hold_stable", bus.bp_info_o, held);
    check1("hold_valid", bus.bp_valid_o, 1'b1);
    step(0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, "flush_only");
    check1("flush_only_valid", bus.bp_valid_o, 1'b0);
    check36("flush_only_info", bus.bp_info_o, held);
    step(0, 1, 32'h1C00_0010, 1, 0, 0, 2'b00, 0, 0, 0, "flush_lookup");
    check1("flush_lookup_valid", bus.bp_valid_o, 1'b1);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] lpc, ppc, bpc, btg;
      bit rst;
      lpc = 32'h1C00_0000 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 15) << 2);
      ppc = 32'h1C00_0000 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 15) << 2);
      bpc = 32'h1C00_0000 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 15) << 2);
      btg = $urandom() & 32'hFFFF_FFFC;
      rst = ($urandom_range(0, 59) == 0);
      step(rst, $urandom_range(0, 2) != 0, lpc, $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) == 1, ppc, 2'($urandom_range(0, 3)),
           $urandom_range(0, 2) == 0, bpc, btg, "rand");
    end

    step(0, 0, 0, 0, 1, 32'h1C00_0010, 2'b11, 1, 32'h1C00_0010, 32'h1C00_0100, "pre_rst_wr");
    step(1, 1, 32'h1C00_0010, 1, 1, 32'h1C00_0020, 2'b11, 1, 32'h1C00_0020, 32'h1C00_0200, "mid_reset");
    lookup(32'h1C00_0010, "post_rst_a");
    check36("post_rst_a_const", bus.bp_info_o, {1'b0, 2'b01, 1'b0, 32'h1C00_0014});
    lookup(32'h1C00_0020, "post_rst_b");
    check36("post_rst_b_const", bus.bp_info_o, {1'b0, 2'b01, 1'b0, 32'h1C00_0024});
    lookup(32'hFFFF_FFFC, "wrap");
    check36("wrap_const", bus.bp_info_o, {1'b0, 2'b01, 1'b0, 32'h0000_0000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
